// File: rtl/seg7_pkg.sv
// Shared constants and types for the seg7_scan_disp eight-digit display scanner.
// Segment vectors are active-low in {CG,CF,CE,CD,CC,CB,CA} order.
package seg7_pkg;

    typedef logic [2:0] dig_idx_t;

    localparam int unsigned NUM_DIGITS = 8;
    localparam dig_idx_t    LAST_DIGIT = dig_idx_t'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Active-low anode pattern with only digit d enabled.
    function automatic logic [7:0] an_select(input dig_idx_t d);
        return ~(8'b0000_0001 << d);
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational 4-bit to active-low seven-segment decoder.
// Glyph shapes come from the seg7_pkg table so every user shares one source.
module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg7_scan_disp.sv
// Time-multiplexed 8-digit hex scanner with a frame-aligned double buffer.
// Define SEG7_LZB_EN to blank leading-zero digits (digit 0 always stays lit).
module seg7_scan_disp
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        load,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int                PCNT_W    = $clog2(DIGIT_CYCLES);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(DIGIT_CYCLES - 1);

    logic [PCNT_W-1:0] r_pcnt;
    dig_idx_t          r_dig;
    logic [31:0]       r_shown;
    logic [31:0]       r_pend;
    logic              r_pend_v;
    logic              r_wrap_q;
    logic [7:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic              r_frame_done;

    logic              w_tick;
    logic              w_wrap;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg_dec;
    logic [7:0]        w_lzb;
    logic              w_off;

    assign w_tick = (r_pcnt == PCNT_LAST);
    assign w_wrap = w_tick && (r_dig == LAST_DIGIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_dig  <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
            r_dig  <= r_dig + dig_idx_t'(1);
        end else begin
            r_pcnt <= r_pcnt + PCNT_W'(1);
        end
    end

    // A load coinciding with the wrap goes straight to the display word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shown  <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else if (load && w_wrap) begin
            r_shown  <= data;
            r_pend_v <= 1'b0;
        end else if (load) begin
            r_pend   <= data;
            r_pend_v <= 1'b1;
        end else if (w_wrap && r_pend_v) begin
            r_shown  <= r_pend;
            r_pend_v <= 1'b0;
        end
    end

    assign w_nib = r_shown[4*r_dig +: 4];

    hex7seg_dec u_dec (
        .i_hex (w_nib),
        .o_seg (w_seg_dec)
    );

`ifdef SEG7_LZB_EN
    always_comb begin
        w_lzb = '0;
        for (int i = 1; i < 8; i++) begin
            w_lzb[i] = ((r_shown >> (4 * i)) == 32'd0);
        end
    end
`else
    assign w_lzb = '0;
`endif

    assign w_off = blank[r_dig] | w_lzb[r_dig];

    // frame_done is delayed one extra cycle so it lines up with the digit-0 anode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_wrap_q     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wrap_q     <= w_wrap;
            r_frame_done <= r_wrap_q;
            if (w_off) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= an_select(r_dig);
                r_seg <= w_seg_dec;
                r_dp  <= ~dp_in[r_dig];
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_disp.sv
// Directed self-checking bench for seg7_scan_disp with DIGIT_CYCLES = 4.
// Expectations follow SEG7_LZB_EN when the bench is built with it.
module tb_seg7_scan_disp;

    localparam int DC = 4;

    localparam logic [6:0] SEGX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic        load;
    logic [7:0]  dp_in;
    logic [7:0]  blank;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int k = 0;

    seg7_scan_disp #(.DIGIT_CYCLES(DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .load       (load),
        .dp_in      (dp_in),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    function automatic int dig_of(input int kk);
        return ((kk - 1) / DC) % 8;
    endfunction

    function automatic logic lzb_off(input logic [31:0] w, input int d);
`ifdef SEG7_LZB_EN
        return (d >= 1) && ((w >> (4 * d)) == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Expected pins after edge k when word w is the displayed word.
    task automatic chk_slot(input string tag, input logic [31:0] w);
        int         d;
        logic       off;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        d     = dig_of(k);
        off   = blank[d] | lzb_off(w, d);
        e_an  = off ? 8'hFF : ~(8'h01 << d);
        e_seg = off ? 7'h7F : SEGX[w[4*d +: 4]];
        e_dp  = off ? 1'b1 : ~dp_in[d];
        e_fd  = (k > 32) && (k % 32 == 1);
        chk({tag, "_an"},  32'(an),         32'(e_an));
        chk({tag, "_seg"}, 32'(seg),        32'(e_seg));
        chk({tag, "_dp"},  32'(dp),         32'(e_dp));
        chk({tag, "_fd"},  32'(frame_done), 32'(e_fd));
    endtask

    initial begin
        rst   = 1'b1;
        data  = '0;
        load  = 1'b0;
        dp_in = '0;
        blank = '0;

        #22;
        chk("rst_an",  32'(an),         32'hFF);
        chk("rst_seg", 32'(seg),        32'h7F);
        chk("rst_dp",  32'(dp),         32'h1);
        chk("rst_fd",  32'(frame_done), 32'h0);
        rst = 1'b0;

        tick();
        chk("first_an",  32'(an),  32'hFE);
        chk("first_seg", 32'(seg), 32'(7'b1000000));
        chk("first_dp",  32'(dp),  32'h1);
        load = 1'b1;
        data = 32'h76543210;

        while (k < 32) begin
            tick();
            load = 1'b0;
            chk_slot("pre", 32'h0);
        end

        while (k < 64) begin
            tick();
            chk_slot("scan", 32'h76543210);
        end

        while (k < 96) begin
            tick();
            chk_slot("tear", 32'h76543210);
            if (k == 76) begin
                load = 1'b1;
                data = 32'hFFFFFFFF;
            end else begin
                load = 1'b0;
            end
        end

        while (k < 128) begin
            tick();
            chk_slot("ffff", 32'hFFFFFFFF);
            chk("ffff_lit", 32'(seg), 32'(7'b0001110));
            if (k == 127) begin
                load = 1'b1;
                data = 32'h0000000A;
            end else begin
                load = 1'b0;
            end
        end

        while (k < 160) begin
            tick();
            load = 1'b0;
            chk_slot("bypass", 32'h0000000A);
            if (dig_of(k) == 0) chk("bypass_lit", 32'(seg), 32'(7'b0001000));
        end
        blank = 8'h80;
        dp_in = 8'h01;

        while (k < 192) begin
            tick();
            chk_slot("blank", 32'h0000000A);
            if (dig_of(k) == 7) chk("blank_an7", 32'(an), 32'hFF);
            if (dig_of(k) == 0) chk("blank_dp0", 32'(dp), 32'h0);
        end
        blank = 8'h00;
        dp_in = 8'h00;

        while (k < 197) begin
            tick();
            chk_slot("tail", 32'h0000000A);
            if (k == 193) begin
                load = 1'b1;
                data = 32'h55555555;
            end else begin
                load = 1'b0;
            end
        end

        #2;
        rst = 1'b1;
        #1;
        chk("midrst_an",  32'(an),         32'hFF);
        chk("midrst_seg", 32'(seg),        32'h7F);
        chk("midrst_dp",  32'(dp),         32'h1);
        chk("midrst_fd",  32'(frame_done), 32'h0);
        #10;
        rst = 1'b0;
        k = 0;

        tick();
        chk("rel_an",  32'(an),  32'hFE);
        chk("rel_seg", 32'(seg), 32'(7'b1000000));
        while (k < 33) begin
            tick();
            chk_slot("discard", 32'h0);
        end
        chk("discard_lit", 32'(seg), 32'(7'b1000000));
        load = 1'b1;
        data = 32'h00000120;

        while (k < 64) begin
            tick();
            load = 1'b0;
            chk_slot("pre_lzb", 32'h0);
        end

        while (k < 96) begin
            tick();
            chk_slot("lzb", 32'h00000120);
`ifdef SEG7_LZB_EN
            if (dig_of(k) >= 3) chk("lzb_an_off", 32'(an), 32'hFF);
`endif
            if (dig_of(k) == 0) chk("lzb_d0", 32'(seg), 32'(7'b1000000));
            if (dig_of(k) == 1) chk("lzb_d1", 32'(seg), 32'(7'b0100100));
            if (dig_of(k) == 2) chk("lzb_d2", 32'(seg), 32'(7'b1111001));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
